and_req_initiator: RTL and testbench

- Initiator/driver for the 8-bit bitwise AND responder.
- Accepts operand pairs on a valid/ready input, drives them onto the responder's a/b inputs and toggles its enable line to trigger evaluation, waits a fixed settle latency, then samples the responder's out.
- Returns the sampled result on a valid/ready response port.
- Optionally self-checks the result against a&b and keeps pass/fail counters.
- Sits between the stimulus source and the AND responder in the unit-level harness.

---
 rtl/and_req_initiator.sv | 150 +++++++++++++++
 tb/tb_and_req_initiator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/and_req_initiator.sv
// and_req_initiator: drives operand pairs into an 8-bit AND responder,
// waits LAT cycles after an enable toggle, then returns the sampled result.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b operand
// input; dut_enable/dut_a/dut_b/dut_out responder side; res_valid/res_ready/
// res_out/res_mismatch response; pass_cnt/fail_cnt counters; busy status.
// Optional macro AND_REQ_SELF_CHECK_EN adds the a&b check and counters.
module and_req_initiator #(
   parameter int WIDTH = 8,
   parameter int LAT   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             dut_enable,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH-1:0] dut_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_out,
   output logic             res_mismatch,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   state_t           state_q;
   logic [3:0]       wait_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             en_q;
   logic             res_valid_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             sample_d;

   // Result is captured on the edge where the wait counter has run out.
   assign sample_d = (state_q == WAIT) && (wait_q == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= 4'd0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         en_q        <= 1'b0;
         res_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= DRIVE;
               end
            end
            DRIVE: begin
               // Level toggle, not a pulse: the responder evaluates on change.
               en_q    <= ~en_q;
               wait_q  <= LAT_M1;
               state_q <= WAIT;
            end
            WAIT: begin
               if (sample_d) begin
                  res_q       <= dut_out;
                  res_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign dut_enable = en_q;
   assign dut_a      = a_q;
   assign dut_b      = b_q;
   assign res_valid  = res_valid_q;
   assign res_out    = res_q;

`ifdef AND_REQ_SELF_CHECK_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] exp_q;
   logic             mis_q;
   logic             mis_d;
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;
   logic [CNT_W-1:0] pass_d;
   logic [CNT_W-1:0] fail_d;

   assign mis_d  = (dut_out != exp_q);
   // Counters stick at all-ones rather than wrapping.
   assign pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_W'(1);
   assign fail_d = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_q  <= '0;
         mis_q  <= 1'b0;
         pass_q <= '0;
         fail_q <= '0;
      end else begin
         if (state_q == IDLE && in_valid && in_ready_q) begin
            exp_q <= in_a & in_b;
         end
         if (sample_d) begin
            mis_q <= mis_d;
            if (mis_d) fail_q <= fail_d;
            else       pass_q <= pass_d;
         end
      end
   end

   assign res_mismatch = mis_q;
   assign pass_cnt     = pass_q;
   assign fail_cnt     = fail_q;
`else
   assign res_mismatch = 1'b0;
   assign pass_cnt     = '0;
   assign fail_cnt     = '0;
`endif

endmodule

// File: tb/tb_and_req_initiator.sv
// Directed bench for and_req_initiator with a toggle-triggered AND
// responder model, plus a CNT_W=2 instance for counter saturation.
module tb_and_req_initiator;

   localparam int LAT = 2;
`ifdef AND_REQ_SELF_CHECK_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        in_valid = 1'b0, res_ready = 1'b0;
   logic [7:0]  in_a = '0, in_b = '0;
   logic        in_ready, dut_enable, res_valid, res_mismatch, busy;
   logic [7:0]  dut_a, dut_b, dut_out, res_out;
   logic [15:0] pass_cnt, fail_cnt;

   logic        in_valid2 = 1'b0;
   logic [7:0]  in_a2 = '0, in_b2 = '0;
   logic        in_ready2, en2, res_valid2, mis2, busy2;
   logic [7:0]  a2, b2, out2, res_out2;
   logic [1:0]  pass2, fail2;

   int vectors = 0;
   int miscompares = 0;

   // Responder: evaluates a&b when it sees its enable line change.
   logic       force_ff = 1'b0;
   logic       en_prev = 1'b0;
   logic [7:0] resp_q = '0;
   always @(posedge clk) begin
      en_prev <= dut_enable;
      if (dut_enable != en_prev)
         resp_q <= force_ff ? 8'hFF : (dut_a & dut_b);
   end
   assign dut_out = resp_q;
   assign out2    = a2 & b2;

   and_req_initiator #(.WIDTH(8), .LAT(LAT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .dut_enable(dut_enable), .dut_a(dut_a), .dut_b(dut_b),
      .dut_out(dut_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_out(res_out), .res_mismatch(res_mismatch),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
   );

   and_req_initiator #(.WIDTH(8), .LAT(LAT), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .in_a(in_a2), .in_b(in_b2),
      .dut_enable(en2), .dut_a(a2), .dut_b(b2),
      .dut_out(out2),
      .res_valid(res_valid2), .res_ready(1'b1),
      .res_out(res_out2), .res_mismatch(mis2),
      .pass_cnt(pass2), .fail_cnt(fail2), .busy(busy2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL rst_busy got %b want 0", busy);
      end
      vectors++;
      if (dut_enable !== 1'b0) begin
         miscompares++; $display("FAIL rst_enable got %b want 0", dut_enable);
      end
      vectors++;
      if (res_valid !== 1'b0) begin
         miscompares++; $display("FAIL rst_res_valid got %b want 0", res_valid);
      end
      vectors++;
      if ({dut_a, dut_b, res_out} !== 24'h0) begin
         miscompares++; $display("FAIL rst_data got %h want 0", {dut_a, dut_b, res_out});
      end
      vectors++;
      if ({pass_cnt, fail_cnt, res_mismatch} !== 33'h0) begin
         miscompares++; $display("FAIL rst_counters got %h/%h want 0", pass_cnt, fail_cnt);
      end
   endtask

   task automatic test_single();
      in_a = 8'hF0; in_b = 8'h3C; in_valid = 1'b1; res_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({in_ready, busy} !== 2'b01) begin
         miscompares++; $display("FAIL single_hs got %b want 01", {in_ready, busy});
      end
      vectors++;
      if ({dut_a, dut_b, dut_enable} !== {8'hF0, 8'h3C, 1'b0}) begin
         miscompares++; $display("FAIL single_drive got %h %h %b want f0 3c 0", dut_a, dut_b, dut_enable);
      end
      tick();
      vectors++;
      if ({dut_enable, res_valid} !== 2'b10) begin
         miscompares++; $display("FAIL single_toggle got %b want 10", {dut_enable, res_valid});
      end
      tick();
      vectors++;
      if (res_valid !== 1'b0) begin
         miscompares++; $display("FAIL single_early got %b want 0", res_valid);
      end
      tick();
      vectors++;
      if ({res_valid, res_out, res_mismatch} !== {1'b1, 8'h30, 1'b0}) begin
         miscompares++; $display("FAIL single_resp got %b %h %b want 1 30 0", res_valid, res_out, res_mismatch);
      end
      vectors++;
      if (pass_cnt !== (SC ? 16'd1 : 16'd0)) begin
         miscompares++; $display("FAIL single_pass got %0d want %0d", pass_cnt, SC ? 1 : 0);
      end
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({res_valid, res_out, in_ready, dut_a} !== {1'b1, 8'h30, 1'b0, 8'hF0}) begin
            miscompares++;
            $display("FAIL bp_hold%0d got %b %h %b %h want 1 30 0 f0", i, res_valid, res_out, in_ready, dut_a);
         end
      end
      in_valid = 1'b0; res_ready = 1'b1;
      tick();
      vectors++;
      if ({res_valid, in_ready, busy} !== 3'b010) begin
         miscompares++; $display("FAIL bp_release got %b want 010", {res_valid, in_ready, busy});
      end
   endtask

   task automatic test_fault();
      int n;
      force_ff = 1'b1;
      in_a = 8'hAA; in_b = 8'h55; in_valid = 1'b1; res_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (res_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (n !== LAT + 1) begin
         miscompares++; $display("FAIL fault_latency got %0d want %0d", n, LAT + 1);
      end
      vectors++;
      if ({res_out, res_mismatch} !== {8'hFF, SC}) begin
         miscompares++; $display("FAIL fault_resp got %h %b want ff %b", res_out, res_mismatch, SC);
      end
      vectors++;
      if ({pass_cnt, fail_cnt} !== {(SC ? 16'd1 : 16'd0), (SC ? 16'd1 : 16'd0)}) begin
         miscompares++; $display("FAIL fault_cnt got %0d/%0d want %0d/%0d", pass_cnt, fail_cnt, SC, SC);
      end
      tick();
      force_ff = 1'b0;
   endtask

   task automatic test_reset_mid();
      in_a = 8'h0F; in_b = 8'hFF; in_valid = 1'b1; res_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      vectors++;
      if (dut_enable !== 1'b1) begin
         miscompares++; $display("FAIL mid_toggle got %b want 1", dut_enable);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({in_ready, busy, dut_enable, res_valid} !== 4'b1000) begin
         miscompares++;
         $display("FAIL mid_reset got %b want 1000", {in_ready, busy, dut_enable, res_valid});
      end
      vectors++;
      if ({pass_cnt, fail_cnt, dut_a} !== 40'h0) begin
         miscompares++; $display("FAIL mid_clear got %h/%h/%h want 0", pass_cnt, fail_cnt, dut_a);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (res_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_noresp%0d got %b want 0", i, res_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] expq[$];
      logic [7:0] e;
      logic prev_en;
      bit   take;
      int   acc, got, tog, last;
      acc = 0; got = 0; tog = 0; last = -1;
      prev_en = dut_enable;
      res_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
         in_valid = (acc < 10);
         in_a = 8'(acc * 37 + 5);
         in_b = 8'(acc * 91 + 200);
         take = in_valid && in_ready;
         tick();
         if (take) begin
            expq.push_back(in_a & in_b);
            acc++;
         end
         if (dut_enable !== prev_en) begin
            if (last >= 0) begin
               vectors++;
               if (cyc - last !== LAT + 3) begin
                  miscompares++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last, LAT + 3);
               end
            end
            last = cyc;
            tog++;
         end
         prev_en = dut_enable;
         if (res_valid === 1'b1) begin
            e = (expq.size() > 0) ? expq.pop_front() : 8'hXX;
            vectors++;
            if (res_out !== e) begin
               miscompares++; $display("FAIL b2b_res%0d got %h want %h", got, res_out, e);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (got !== 10 || tog !== 10) begin
         miscompares++; $display("FAIL b2b_count got %0d resp %0d toggles want 10 10", got, tog);
      end
      vectors++;
      if (pass_cnt !== (SC ? 16'd10 : 16'd0)) begin
         miscompares++; $display("FAIL b2b_pass got %0d want %0d", pass_cnt, SC ? 10 : 0);
      end
   endtask

   task automatic test_saturation();
      int n;
      for (int k = 0; k < 5; k++) begin
         in_a2 = 8'(k + 1); in_b2 = 8'hFF; in_valid2 = 1'b1;
         tick();
         in_valid2 = 1'b0;
         n = 0;
         while (res_valid2 !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         vectors++;
         if (res_out2 !== 8'(k + 1) || n >= 20) begin
            miscompares++; $display("FAIL sat_res%0d got %h want %h", k, res_out2, 8'(k + 1));
         end
         tick();
      end
      vectors++;
      if ({pass2, fail2} !== {(SC ? 2'd3 : 2'd0), 2'd0}) begin
         miscompares++; $display("FAIL sat_pass got %0d/%0d want %0d/0", pass2, fail2, SC ? 3 : 0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_fault();
      test_reset_mid();
      test_back_to_back();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
